// File: rtl/raster_tile_subdiv_pkg.sv
// Shared types and sizing for the raster tile subdivision stage.
// Optional build macro RASTER_SUBDIV_STATS_EN is consumed by raster_tile_subdiv.
package raster_tile_subdiv_pkg;

    localparam int RASTER_PID_BITS      = 8;
    localparam int RASTER_DIM_BITS      = 16;
    localparam int RASTER_DATA_BITS     = 32;
    localparam int RASTER_TILE_LOGSIZE  = 5;
    localparam int RASTER_BLOCK_LOGSIZE = 2;
    localparam int RASTER_BLOCKS_PER_SIDE = 1 << (RASTER_TILE_LOGSIZE - RASTER_BLOCK_LOGSIZE);

    typedef logic signed [RASTER_DATA_BITS-1:0] raster_data_t;

    // Packed as {a,b,c} so an edge occupies the same bits as the flat edge bus.
    typedef struct packed {
        raster_data_t a;
        raster_data_t b;
        raster_data_t c;
    } raster_edge_t;

    typedef struct packed {
        logic [RASTER_PID_BITS-1:0] pid;
        logic [RASTER_DIM_BITS-1:0] xloc;
        logic [RASTER_DIM_BITS-1:0] yloc;
        raster_edge_t [2:0]         edges;
    } raster_block_t;

    // v * (2^logsize - 1) as shift-minus-operand, wrapping in the data width.
    function automatic raster_data_t mul_side_m1(input raster_data_t v, input int logsize);
        return (v <<< logsize) - v;
    endfunction

endpackage

// File: rtl/raster_tile_subdiv_edge_extent.sv
// Trivial-reject test for a square block: each edge evaluated at the block corner
// that maximises it; the block survives only if no edge is negative there.
module raster_tile_subdiv_edge_extent
    import raster_tile_subdiv_pkg::*;
#(
    parameter int BLOCK_LOGSIZE = RASTER_BLOCK_LOGSIZE
) (
    input  raster_edge_t [2:0] edges_i,
    output raster_data_t [2:0] ext_o,
    output logic               accept_o
);

    // NOTE: every signal written in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        accept_o = 1'b1;
        ext_o    = '0;
        for (int i = 0; i < 3; i++) begin
            ext_o[i] = edges_i[i].c
                     + ((edges_i[i].a > 0) ? mul_side_m1(edges_i[i].a, BLOCK_LOGSIZE) : '0)
                     + ((edges_i[i].b > 0) ? mul_side_m1(edges_i[i].b, BLOCK_LOGSIZE) : '0);
            accept_o = accept_o & ~ext_o[i][RASTER_DATA_BITS-1];
        end
    end

endmodule

// File: rtl/raster_tile_subdiv.sv
// Walks a tile in sub-blocks, rejects blocks fully outside an edge and emits the
// rest through an elastic buffer. Optional macro: RASTER_SUBDIV_STATS_EN.
module raster_tile_subdiv
    import raster_tile_subdiv_pkg::*;
#(
    parameter int TILE_LOGSIZE  = RASTER_TILE_LOGSIZE,
    parameter int BLOCK_LOGSIZE = RASTER_BLOCK_LOGSIZE,
    parameter int OUT_BUF_SIZE  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_in,
    input  logic [RASTER_PID_BITS-1:0] pid_in,
    input  logic [RASTER_DIM_BITS-1:0] xloc_in,
    input  logic [RASTER_DIM_BITS-1:0] yloc_in,
    input  raster_edge_t [2:0]         edges_in,
    output logic                       ready_in,
    output logic                       valid_out,
    output logic [RASTER_PID_BITS-1:0] pid_out,
    output logic [RASTER_DIM_BITS-1:0] xloc_out,
    output logic [RASTER_DIM_BITS-1:0] yloc_out,
    output raster_edge_t [2:0]         edges_out,
    input  logic                       ready_out,
    output logic                       busy
`ifdef RASTER_SUBDIV_STATS_EN
    ,
    output logic [31:0]                perf_blocks_in,
    output logic [31:0]                perf_blocks_out
`endif
);

    localparam int CNT_W = TILE_LOGSIZE - BLOCK_LOGSIZE;
    localparam logic [CNT_W-1:0] LAST_BLK = '1;
    localparam int PTR_W  = (OUT_BUF_SIZE > 1) ? $clog2(OUT_BUF_SIZE) : 1;
    localparam int FILL_W = $clog2(OUT_BUF_SIZE + 1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(OUT_BUF_SIZE - 1);
    localparam logic [FILL_W-1:0] BUF_FULL = FILL_W'(OUT_BUF_SIZE);

    typedef enum logic {IDLE, WALK} state_t;

    state_t                     state_q;
    logic [CNT_W-1:0]           bx_q, by_q;
    logic [RASTER_PID_BITS-1:0] pid_q;
    logic [RASTER_DIM_BITS-1:0] xloc_q, yloc_q;
    raster_data_t [2:0]         a_q, b_q, cur_c_q, row_c_q;

    raster_edge_t [2:0] cur_edges;
    raster_data_t [2:0] row_c_d;
    raster_block_t      blk;
    logic               blk_accept;
    logic               buf_ready, push, pop, advance;

    raster_block_t              mem_q [OUT_BUF_SIZE];
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0]          fill_q;

    always_comb begin
        cur_edges = '0;
        row_c_d   = '0;
        for (int i = 0; i < 3; i++) begin
            cur_edges[i] = '{a: a_q[i], b: b_q[i], c: cur_c_q[i]};
            row_c_d[i]   = row_c_q[i] + (b_q[i] <<< BLOCK_LOGSIZE);
        end
        blk.pid   = pid_q;
        blk.xloc  = xloc_q + (RASTER_DIM_BITS'(bx_q) << BLOCK_LOGSIZE);
        blk.yloc  = yloc_q + (RASTER_DIM_BITS'(by_q) << BLOCK_LOGSIZE);
        blk.edges = cur_edges;
    end

    raster_tile_subdiv_edge_extent #(
        .BLOCK_LOGSIZE (BLOCK_LOGSIZE)
    ) u_extent (
        .edges_i  (cur_edges),
        .ext_o    (),
        .accept_o (blk_accept)
    );

    // Accepted blocks wait for buffer space; rejected blocks never stall the walk.
    assign buf_ready = (fill_q != BUF_FULL);
    assign push      = (state_q == WALK) && blk_accept && buf_ready;
    assign advance   = (state_q == WALK) && (!blk_accept || buf_ready);
    assign pop       = valid_out && ready_out;

    assign ready_in  = (state_q == IDLE);
    assign busy      = (state_q == WALK) || (fill_q != '0);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bx_q    <= '0;
            by_q    <= '0;
            pid_q   <= '0;
            xloc_q  <= '0;
            yloc_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cur_c_q <= '0;
            row_c_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        pid_q  <= pid_in;
                        xloc_q <= xloc_in;
                        yloc_q <= yloc_in;
                        bx_q   <= '0;
                        by_q   <= '0;
                        for (int i = 0; i < 3; i++) begin
                            a_q[i]     <= edges_in[i].a;
                            b_q[i]     <= edges_in[i].b;
                            cur_c_q[i] <= edges_in[i].c;
                            row_c_q[i] <= edges_in[i].c;
                        end
                        state_q <= WALK;
                    end
                end
                WALK: begin
                    if (advance) begin
                        if (bx_q != LAST_BLK) begin
                            bx_q <= bx_q + 1'b1;
                            for (int i = 0; i < 3; i++)
                                cur_c_q[i] <= cur_c_q[i] + (a_q[i] <<< BLOCK_LOGSIZE);
                        end else begin
                            bx_q    <= '0;
                            by_q    <= by_q + 1'b1;
                            row_c_q <= row_c_d;
                            cur_c_q <= row_c_d;
                            if (by_q == LAST_BLK)
                                state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: buffer storage has no reset; the fill count alone decides validity,
    // so the array can map to plain registers or RAM without reset muxing.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= blk;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push)
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Head entry is only overwritten after it is popped, so outputs hold under stall.
    assign valid_out = (fill_q != '0);
    assign pid_out   = mem_q[rd_ptr_q].pid;
    assign xloc_out  = mem_q[rd_ptr_q].xloc;
    assign yloc_out  = mem_q[rd_ptr_q].yloc;
    assign edges_out = mem_q[rd_ptr_q].edges;

`ifdef RASTER_SUBDIV_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_blocks_in  <= '0;
            perf_blocks_out <= '0;
        end else begin
            if (advance)
                perf_blocks_in <= perf_blocks_in + 32'd1;
            if (push)
                perf_blocks_out <= perf_blocks_out + 32'd1;
        end
    end
`else
    // Statistics counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_raster_tile_subdiv.sv
// Scoreboard bench for raster_tile_subdiv: a closed-form block model fills the
// expected queue at stimulus time; a negedge monitor pops and compares outputs.
module tb_raster_tile_subdiv;
    import raster_tile_subdiv_pkg::*;

    localparam int BS = 1 << RASTER_BLOCK_LOGSIZE;
    localparam int NB = RASTER_BLOCKS_PER_SIDE;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       valid_in;
    logic [RASTER_PID_BITS-1:0] pid_in;
    logic [RASTER_DIM_BITS-1:0] xloc_in, yloc_in;
    raster_edge_t [2:0]         edges_in;
    logic                       ready_in;
    logic                       valid_out;
    logic [RASTER_PID_BITS-1:0] pid_out;
    logic [RASTER_DIM_BITS-1:0] xloc_out, yloc_out;
    raster_edge_t [2:0]         edges_out;
    logic                       ready_out;
    logic                       busy;
`ifdef RASTER_SUBDIV_STATS_EN
    logic [31:0]                perf_blocks_in, perf_blocks_out;
`endif

    raster_block_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    int last_wait = 0;

    always #5 clk = ~clk;

    raster_tile_subdiv dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .pid_in    (pid_in),
        .xloc_in   (xloc_in),
        .yloc_in   (yloc_in),
        .edges_in  (edges_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .pid_out   (pid_out),
        .xloc_out  (xloc_out),
        .yloc_out  (yloc_out),
        .edges_out (edges_out),
        .ready_out (ready_out),
        .busy      (busy)
`ifdef RASTER_SUBDIV_STATS_EN
        ,
        .perf_blocks_in  (perf_blocks_in),
        .perf_blocks_out (perf_blocks_out)
`endif
    );

    function automatic raster_edge_t mk_edge(input int a, input int b, input int c);
        raster_edge_t e;
        e.a = a;
        e.b = b;
        e.c = c;
        return e;
    endfunction

    function automatic raster_block_t cur_block();
        raster_block_t r;
        r.pid   = pid_out;
        r.xloc  = xloc_out;
        r.yloc  = yloc_out;
        r.edges = edges_out;
        return r;
    endfunction

    // Closed form: c at block (bx,by) = c0 + a*bx*BS + b*by*BS, all mod 2^32.
    task automatic model_tile(input logic [RASTER_PID_BITS-1:0] pid,
                              input logic [RASTER_DIM_BITS-1:0] x,
                              input logic [RASTER_DIM_BITS-1:0] y,
                              input raster_edge_t [2:0] e);
        raster_block_t r;
        raster_data_t  cur, ext;
        bit            ok;
        for (int by = 0; by < NB; by++) begin
            for (int bx = 0; bx < NB; bx++) begin
                ok = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    cur = e[i].c + e[i].a * (bx * BS) + e[i].b * (by * BS);
                    ext = cur + ((e[i].a > 0) ? e[i].a * (BS - 1) : 0)
                              + ((e[i].b > 0) ? e[i].b * (BS - 1) : 0);
                    if (ext < 0) ok = 1'b0;
                    r.edges[i] = mk_edge(e[i].a, e[i].b, cur);
                end
                r.pid  = pid;
                r.xloc = x + RASTER_DIM_BITS'(bx * BS);
                r.yloc = y + RASTER_DIM_BITS'(by * BS);
                if (ok) sb_q.push_back(r);
            end
        end
    endtask

    always @(negedge clk) begin
        raster_block_t act, exp_b;
        if (reset && valid_out && ready_out) begin
            act = cur_block();
            n_cmp++;
            n_out++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out got pid=%0d x=%0d y=%0d required none", pid_out, xloc_out, yloc_out);
            end else begin
                exp_b = sb_q.pop_front();
                if (act !== exp_b) begin
                    n_err++;
                    $display("FAIL block_out got %h required %h", act, exp_b);
                end
            end
        end
    end

    task automatic send_tile(input logic [RASTER_PID_BITS-1:0] pid,
                             input logic [RASTER_DIM_BITS-1:0] x,
                             input logic [RASTER_DIM_BITS-1:0] y,
                             input raster_edge_t [2:0] e);
        @(negedge clk);
        valid_in = 1'b1;
        pid_in   = pid;
        xloc_in  = x;
        yloc_in  = y;
        edges_in = e;
        last_wait = 0;
        while (!ready_in && last_wait < 2000) begin
            @(negedge clk);
            last_wait++;
        end
        if (!ready_in) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout got ready_in=0 required 1 within 2000 cycles");
        end else begin
            model_tile(pid, x, y, e);
        end
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int exp_out);
        int cyc = 0;
        @(negedge clk);
        while ((busy || sb_q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (busy || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain got busy=%0b pending=%0d required idle and empty", name, busy, sb_q.size());
        end
        if (exp_out >= 0) begin
            n_cmp++;
            if (n_out != exp_out) begin
                n_err++;
                $display("FAIL %s_count got %0d outputs required %0d", name, n_out, exp_out);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        valid_in = 1'b0;
        ready_out = 1'b1;
        pid_in = '0;
        xloc_in = '0;
        yloc_in = '0;
        edges_in = '0;
        repeat (2) @(negedge clk);
        n_cmp += 3;
        if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out got %b required 0", valid_out); end
        if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b required 0", busy); end
        if (ready_in !== 1'b1)  begin n_err++; $display("FAIL reset_ready_in got %b required 1", ready_in); end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_partial_edge();
        raster_edge_t [2:0] e;
        e[0] = mk_edge(1, 0, -20);
        e[1] = mk_edge(0, 0, 1);
        e[2] = mk_edge(0, 0, 1);
        n_out = 0;
        send_tile(8'd1, 16'd64, 16'd32, e);
        wait_drain("partial", 24);
    endtask

    task automatic test_all_reject();
        raster_edge_t [2:0] e;
        int cyc = 0;
        for (int i = 0; i < 3; i++) e[i] = mk_edge(0, 0, -1);
        n_out = 0;
        send_tile(8'd2, 16'd0, 16'd0, e);
        @(negedge clk);
        while (busy && cyc < 500) begin
            cyc++;
            @(negedge clk);
        end
        n_cmp += 3;
        if (cyc != NB * NB) begin n_err++; $display("FAIL reject_walk_len got %0d cycles required %0d", cyc, NB * NB); end
        if (ready_in !== 1'b1) begin n_err++; $display("FAIL reject_ready_in got %b required 1", ready_in); end
        if (n_out != 0) begin n_err++; $display("FAIL reject_count got %0d outputs required 0", n_out); end
    endtask

    task automatic test_stall();
        raster_edge_t [2:0] e;
        raster_block_t act;
        int cyc = 0;
        for (int i = 0; i < 3; i++) e[i] = mk_edge(0, 0, 5);
        n_out = 0;
        ready_out = 1'b0;
        send_tile(8'd4, 16'd100, 16'd200, e);
        while (!valid_out && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            act = cur_block();
            n_cmp++;
            if (!valid_out || sb_q.size() == 0 || act !== sb_q[0]) begin
                n_err++;
                $display("FAIL stall_hold cycle %0d got valid=%b x=%0d y=%0d required first block x=100 y=200",
                         k, valid_out, xloc_out, yloc_out);
            end
        end
        ready_out = 1'b1;
        wait_drain("stall", 64);
    endtask

    task automatic test_back_to_back();
        raster_edge_t [2:0] e;
        int hi = 0;
        for (int i = 0; i < 3; i++) e[i] = mk_edge(1, 1, 0);
        n_out = 0;
        send_tile(8'd3, 16'd0, 16'd0, e);
        for (int k = 0; k < NB * NB; k++) begin
            @(negedge clk);
            if (ready_in !== 1'b0) hi++;
        end
        n_cmp++;
        if (hi != 0) begin n_err++; $display("FAIL b2b_ready_low got %0d high cycles required 0", hi); end
        send_tile(8'd7, 16'd32, 16'd0, e);
        n_cmp++;
        if (last_wait != 0) begin n_err++; $display("FAIL b2b_bubble got %0d wait cycles required 0", last_wait); end
        wait_drain("b2b", 2 * NB * NB);
    endtask

    task automatic test_reset_mid_walk();
        raster_edge_t [2:0] e;
        for (int i = 0; i < 3; i++) e[i] = mk_edge(0, 0, 5);
        send_tile(8'd5, 16'd0, 16'd0, e);
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_cmp += 3;
        if (valid_out !== 1'b0) begin n_err++; $display("FAIL midrst_valid_out got %b required 0", valid_out); end
        if (busy !== 1'b0)      begin n_err++; $display("FAIL midrst_busy got %b required 0", busy); end
        if (ready_in !== 1'b1)  begin n_err++; $display("FAIL midrst_ready_in got %b required 1", ready_in); end
        sb_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        n_out = 0;
        send_tile(8'd9, 16'd8, 16'd8, e);
        wait_drain("midrst", 64);
    endtask

    task automatic test_wrap();
        raster_edge_t [2:0] e;
        e[0] = mk_edge(8, 0, 32'h7FFF_FFF0);
        e[1] = mk_edge(0, 0, 1);
        e[2] = mk_edge(0, 0, 1);
        n_out = 0;
        send_tile(8'd11, 16'd0, 16'd0, e);
        wait_drain("wrap_all", 0);
        e[0] = mk_edge(8, 0, 32'h7FFF_FFE0);
        n_out = 0;
        send_tile(8'd12, 16'hFFF0, 16'hFFF0, e);
        wait_drain("wrap_col0", NB);
    endtask

    task automatic test_random();
        raster_edge_t [2:0] e;
        bit done = 1'b0;
        n_out = 0;
        fork
            begin
                for (int t = 0; t < 4; t++) begin
                    for (int i = 0; i < 3; i++)
                        e[i] = mk_edge($urandom_range(16) - 8, $urandom_range(16) - 8, $urandom_range(128) - 64);
                    send_tile(8'(20 + t), 16'($urandom), 16'($urandom), e);
                end
                wait_drain("random", -1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 ready_out = ($urandom_range(3) != 0);
                end
                ready_out = 1'b1;
            end
        join
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_partial_edge();
        test_all_reject();
        test_stall();
        test_back_to_back();
        test_reset_mid_walk();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/raster_tile_subdiv.md
Name: raster_tile_subdiv

Overview:
Rasterizer stage directly downstream of the raster memory unit. It consumes one (tile, primitive) record per handshake: tile position, pid and 3 edge equations. It walks the tile in fixed-size sub-blocks, trivially rejects blocks lying fully outside any edge, and emits the surviving blocks to the block/quad evaluator with edge constants rebased to the block origin.

Parameters:
TILE_LOGSIZE, 5, log2 of tile side in pixels; must match the memory unit.
BLOCK_LOGSIZE, 2, log2 of block side in pixels; must be less than TILE_LOGSIZE.
OUT_BUF_SIZE, 2, depth of the output elastic buffer, at least 1.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
valid_in  in  1  input record valid
pid_in  in  VX_RASTER_PID_BITS  primitive id
xloc_in  in  VX_RASTER_DIM_BITS  tile origin x
yloc_in  in  VX_RASTER_DIM_BITS  tile origin y
edges_in  in  [2:0][2:0]RASTER_DATA_BITS  per edge i: {a,b,c}; c is the edge value at the tile origin
ready_in  out  1  accept input
valid_out  out  1  block valid
pid_out  out  VX_RASTER_PID_BITS  primitive id
xloc_out  out  VX_RASTER_DIM_BITS  block origin x
yloc_out  out  VX_RASTER_DIM_BITS  block origin y
edges_out  out  [2:0][2:0]RASTER_DATA_BITS  a, b unchanged; c rebased to the block origin
ready_out  in  1  downstream accept
busy  out  1  walk in progress or output buffer non-empty

Behaviour:
- Constants: N = 2^(TILE_LOGSIZE-BLOCK_LOGSIZE) blocks per side; BS = 2^BLOCK_LOGSIZE.
- Arithmetic: all edge arithmetic is signed two's complement in RASTER_DATA_BITS and wraps silently.
- Reset (asserted low, asynchronous):
  - FSM goes to IDLE; block counters bx, by are 0.
  - Output buffer is emptied, so valid_out=0.
  - busy=0 and ready_in=1.
- FSM IDLE:
  - ready_in=1.
  - On valid_in&&ready_in, latch pid, xloc, yloc and edges.
  - Set row_c[i]=cur_c[i]=c_i and bx=by=0, then go to WALK.
- FSM WALK:
  - ready_in=0.
  - Each cycle, evaluate the current block combinationally from registered state.
  - Per edge: ext_i = cur_c[i] + (a_i>0 ? a_i*(BS-1) : 0) + (b_i>0 ? b_i*(BS-1) : 0). Multiplication by BS-1 is done as a shift minus the operand; no multiplier.
  - The block is accepted iff ext_i >= 0 for all three edges.
- Advance rule:
  - Accepted block: push {pid, xloc+bx*BS, yloc+by*BS, edges with c=cur_c} into the output buffer. Advance only when the push fires.
  - Rejected block: advance unconditionally in the same cycle. Throughput is 1 block/cycle.
- Advance step:
  - If bx<N-1: bx++ and cur_c += a<<BLOCK_LOGSIZE.
  - Otherwise: bx=0, by++, row_c += b<<BLOCK_LOGSIZE, and cur_c = the new row_c.
- Last block: advancing from (N-1, N-1) returns to IDLE. A new input can be accepted the following cycle, with no bubble beyond that one cycle.
- Coordinates: xloc_out/yloc_out are computed modulo 2^VX_RASTER_DIM_BITS.
- Tile with all blocks rejected: zero outputs. Returns to IDLE after exactly N*N WALK cycles.
- Output handshake: valid/ready through the elastic buffer. Once valid_out is high, all output fields stay stable until ready_out.
- Ordering: blocks are emitted in raster order, x fastest. Inputs are processed strictly in order.

Optional Feature:
RASTER_SUBDIV_STATS_EN
- With the macro: extra outputs perf_blocks_in and perf_blocks_out, each 32 bits, reset to 0.
  - perf_blocks_in counts every evaluated block.
  - perf_blocks_out counts every accepted block pushed.
  - Both wrap.
- Without the macro: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- VX_raster_pkg gains:
  - the localparam for block count per side;
  - a raster_edge_t typedef (struct {a,b,c} of RASTER_DATA_BITS);
  - a raster_block_t typedef (pid, xloc, yloc, edges).
- One natural sub-module: raster_edge_extent. It is combinational, 3 edges in, accept flag and extents out, and is reusable by the quad evaluator.
- The output buffer is the existing VX_elastic_buffer.

Test Plan:
- 32x32 tile, 4x4 blocks, xloc=64, yloc=32. Edge0 {1,0,-20}; edges 1 and 2 {0,0,1}.
  -> 24 outputs, columns bx=5..7 of each row.
  -> First output x=84, y=32, edge0 c=0. Last output x=92, y=60, edge0 c=8.
- All edges {0,0,-1}.
  -> No valid_out. busy drops and ready_in returns 64 cycles after acceptance.
- All edges {0,0,5}, with ready_out held low for 10 cycles.
  -> The first block (x=xloc, y=yloc) stays stable. After release, 64 outputs in raster order with no drops or duplicates.
- Two back-to-back inputs (pid 3, then pid 7), all blocks accepted.
  -> 64 outputs for pid 3, then 64 for pid 7. ready_in is low throughout the first walk.
- Reset pulsed low mid-walk at block 10.
  -> valid_out=0, busy=0 and ready_in=1 immediately. The next input walks from bx=by=0.
- Edge c=0x7FFFFFF0, a=8.
  -> cur_c wraps negative. Those blocks are rejected exactly as the wrapped value dictates; no X values or assertions.
